// File: rtl/fifo_pkg.sv
// Shared default geometry for the byte FIFO and its storage array.
package fifo_pkg;
  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_ADDR_W = 4;
endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without an occupancy counter.
module sync_byte_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic              winc,
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rinc,
  output logic              wfull,
  output logic              rempty
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              we;
  logic              re;

  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                  (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  // Requests against the wrong flag are silently dropped.
  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (we) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (re) begin
      rptr_d  = rptr_q + PTR_W'(1);
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : sync_byte_fifo

// File: tb/tb_sync_byte_fifo.sv
// Directed self-checking bench for sync_byte_fifo.
module tb_sync_byte_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic       wfull;
  logic       rempty;

  int n_chk = 0;
  int n_bad = 0;

  sync_byte_fifo dut (
    .rdata  (rdata),
    .wdata  (wdata),
    .winc   (winc),
    .clk    (clk),
    .rst_n  (rst_n),
    .rinc   (rinc),
    .wfull  (wfull),
    .rempty (rempty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; outputs are settled at the following negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(negedge clk);
    winc  = 1'b0;
    rinc  = 1'b0;
  endtask

  logic [7:0] trunc_in  [5];
  logic [7:0] trunc_exp [5];

  initial begin
    rst_n = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'd0;
    #1;
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull",  32'(wfull),  32'd0);
    chk("rst_rdata",  32'(rdata),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic order
    cyc(1'b1, 8'd1, 1'b0);
    chk("basic_notempty", 32'(rempty), 32'd0);
    cyc(1'b1, 8'd20, 1'b0);
    cyc(1'b1, 8'd30, 1'b0);
    cyc(1'b1, 8'd40, 1'b0);
    chk("basic_wfull", 32'(wfull), 32'd0);
    cyc(1'b0, 8'd0, 1'b1); chk("basic_rd0", 32'(rdata), 32'd1);
    cyc(1'b0, 8'd0, 1'b1); chk("basic_rd1", 32'(rdata), 32'd20);
    cyc(1'b0, 8'd0, 1'b1); chk("basic_rd2", 32'(rdata), 32'd30);
    chk("basic_rempty_mid", 32'(rempty), 32'd0);
    cyc(1'b0, 8'd0, 1'b1); chk("basic_rd3", 32'(rdata), 32'd40);
    chk("basic_rempty_end", 32'(rempty), 32'd1);

    // caller-side truncation
    trunc_in[0] = 8'(1000); trunc_exp[0] = 8'd232;
    trunc_in[1] = 8'(1020); trunc_exp[1] = 8'd252;
    trunc_in[2] = 8'(1300); trunc_exp[2] = 8'd20;
    trunc_in[3] = 8'(1040); trunc_exp[3] = 8'd16;
    trunc_in[4] = 8'(1050); trunc_exp[4] = 8'd26;
    for (int i = 0; i < 5; i++) cyc(1'b1, trunc_in[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk($sformatf("trunc_rd%0d", i), 32'(rdata), 32'(trunc_exp[i]));
    end
    chk("trunc_rempty", 32'(rempty), 32'd1);

    // fill to full, overflow write dropped
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk($sformatf("full_wfull%0d", i), 32'(wfull), (i == 15) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 8'd16, 1'b0);
    chk("ovf_wfull", 32'(wfull), 32'd1);
    // write on full with concurrent read: write dropped, read proceeds
    cyc(1'b1, 8'd77, 1'b1);
    chk("ovf_rd0", 32'(rdata), 32'd0);
    chk("ovf_wfull_drop", 32'(wfull), 32'd0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk($sformatf("full_rd%0d", i), 32'(rdata), 32'(i));
    end
    chk("full_rempty", 32'(rempty), 32'd1);

    // underflow: reads on empty are dropped and rdata holds
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk($sformatf("unf_rdata%0d", i), 32'(rdata), 32'd15);
      chk($sformatf("unf_rempty%0d", i), 32'(rempty), 32'd1);
    end
    cyc(1'b1, 8'd55, 1'b1);
    chk("unf_wr_rempty", 32'(rempty), 32'd0);
    chk("unf_wr_rdata", 32'(rdata), 32'd15);
    cyc(1'b0, 8'd0, 1'b1);
    chk("unf_rd55", 32'(rdata), 32'd55);
    chk("unf_rempty_end", 32'(rempty), 32'd1);

    // wrap with simultaneous traffic
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(10 + i), 1'b1);
      chk($sformatf("wrap_rd%0d", i), 32'(rdata), 32'(i));
      chk($sformatf("wrap_flags%0d", i), {30'd0, wfull, rempty}, 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk($sformatf("drain_rd%0d", i), 32'(rdata), 32'(40 + i));
    end
    chk("drain_rempty", 32'(rempty), 32'd1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(200 + i), 1'b0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("arst_pre_rd", 32'(rdata), 32'd200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rempty", 32'(rempty), 32'd1);
    chk("arst_wfull",  32'(wfull),  32'd0);
    chk("arst_rdata",  32'(rdata),  32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 8'd100, 1'b0);
    chk("arst_wr_rempty", 32'(rempty), 32'd0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("arst_rd100", 32'(rdata), 32'd100);
    chk("arst_rempty_end", 32'(rempty), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_sync_byte_fifo

// File: doc/sync_byte_fifo.md
Name: sync_byte_fifo

Overview:
- Single-clock, first-in first-out byte buffer used as an elastic store between a producer and a consumer in the same clock domain.
- Producer pushes with winc/wdata; consumer pops with rinc and receives the word on rdata.
- wfull and rempty flags provide flow control.
- Overflowing writes and underflowing reads are dropped safely.

Parameters:
- DATA_W, 8, width of each stored word and of wdata/rdata.
- ADDR_W, 4, address width; depth = 2**ADDR_W (16 entries).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- rdata  output  DATA_W  registered read data.
- wdata  input  DATA_W  write data, sampled on rising clk when a write is accepted.
- winc  input  1  write request, level-sensitive, one word per clock while high.
- rinc  input  1  read request, level-sensitive, one word per clock while high.
- wfull  output  1  high when the FIFO holds 2**ADDR_W words.
- rempty  output  1  high when the FIFO holds 0 words.

Positional order (legacy callers): rdata, wdata, winc, clk, rst_n, rinc, wfull, rempty.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - wptr = rptr = 0, rdata = 0, rempty = 1, wfull = 0.
  - Memory contents are not cleared and are don't-care.
  - Reset asserted mid-operation discards all stored data immediately.
- Pointers: wptr and rptr are ADDR_W+1 bits wide. The low ADDR_W bits address memory; the MSB is the wrap bit.
- Flags, combinational from the registered pointers:
  - rempty = (wptr == rptr).
  - wfull = (low bits equal) and (MSBs differ).
- Write accept: we = winc & ~wfull. On the rising edge, mem[wptr[ADDR_W-1:0]] <= wdata and wptr increments.
- Read accept: re = rinc & ~rempty.
  - On the rising edge, rdata <= mem[rptr[ADDR_W-1:0]] and rptr increments.
  - Latency: a word is visible on rdata immediately after the edge that accepts the read.
  - rdata holds its value when no read is accepted.
- Write to a full FIFO: dropped. Pointer, memory and flags are unchanged, even if rinc is high in the same cycle; the read proceeds.
- Read from an empty FIFO: dropped. rdata and rptr are unchanged, even if winc is high in the same cycle; the write proceeds. No read-through on empty.
- Simultaneous accepted read and write (neither full nor empty): both happen. Occupancy is unchanged and flags are unchanged.
- Wrap-around: pointers roll over modulo 2**(ADDR_W+1). Ordering is preserved across the wrap.
- Data width: values wider than DATA_W are truncated by the caller's assignment; the FIFO stores exactly DATA_W bits.
- Flags update in the same cycle as the pointer change.
- No X is propagated from uninitialised memory unless a read is accepted (never when empty).

Decomposition:
- Package fifo_pkg holds the default constants FIFO_DATA_W = 8 and FIFO_ADDR_W = 4.
- One sub-module, fifo_mem: a simple dual-port register array with synchronous write and combinational read. No reset.
- Pointer and flag logic stays in sync_byte_fifo.

Test Plan:
- Basic order: reset, then write 1, 20, 30, 40 on consecutive cycles, then read 4 times. rdata = 1, 20, 30, 40 in order. rempty returns to 1 after the 4th read; wfull stays 0 throughout.
- Truncation: write 8'd1000, 8'd1020, 8'd1300, 8'd1040, 8'd1050 (caller-truncated), then read 5 times. rdata = 232, 252, 20, 16, 26.
- Full/overflow: write 0..16 (17 writes). wfull = 1 after the 16th write and the 17th is dropped. Reading 16 times yields 0..15, then rempty = 1.
- Underflow: on empty, hold rinc = 1 for 3 cycles. rdata keeps its previous value and rempty stays 1. Then a simultaneous winc with wdata = 55 and rinc: the write is accepted, the read is rejected, and rempty falls.
- Wrap/simultaneous:
  - Fill 10 words, then run 40 cycles with winc = rinc = 1 on an incrementing pattern.
  - Output sequence stays contiguous and the flags never toggle.
  - Then drain the FIFO and check order is preserved.
- Async reset mid-operation: with 5 words stored, pulse rst_n low between clock edges. Immediately rempty = 1, wfull = 0, rdata = 0. The next write of 100 followed by a read returns 100.
